// File: rtl/trace_capture_if.sv
// Read-side valid/ready channel of the trace FIFO.
// The master (trace_capture) presents the head entry; the slave (reader) accepts it.
interface trace_capture_if;
  logic        rd_valid;
  logic [36:0] rd_data;
  logic        rd_ready;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/trace_capture.sv
// Instruction-trace capture: arm/trigger FSM feeding a first-word-fall-through FIFO
// of {pc, ir, rq0} records, one record per processor decode.
//
// state   | meaning
// IDLE    | out of reset, waiting for arm
// ARMED   | flushed, waiting for a decode that satisfies the trigger
// CAPTURE | every decode is pushed; halt stops capture
// STOPPED | capture finished, FIFO still drains, waiting for re-arm
module trace_capture #(
  parameter int         DEPTH        = 8,
  parameter int         AW           = 3,
  parameter logic [3:0] DECODE_STATE = 4'd2,
  parameter logic [3:0] HALT_STATE   = 4'd7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               arm,
  input  logic               trig_any,
  input  logic [4:0]         trig_pc,
  input  logic [15:0]        ir_out,
  input  logic [4:0]         pc_out,
  input  logic [3:0]         state_o,
  input  logic [15:0]        rq0,
  trace_capture_if.master    rd,
  output logic [1:0]         cap_state,
  output logic [AW:0]        count,
  output logic               overflow
);

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_ARMED   = 2'b01;
  localparam logic [1:0] S_CAPTURE = 2'b10;
  localparam logic [1:0] S_STOPPED = 2'b11;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [36:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [3:0]    prev_state;
  logic [1:0]    state_nx;

  logic        dev;
  logic        hev;
  logic        trig_hit;
  logic        push_req;
  logic        push_ok;
  logic        push_drop;
  logic        pop;
  logic        full;
  logic [36:0] record;

  // Edge-detect on the processor state so a multi-cycle decode yields one event.
  assign dev      = (state_o == DECODE_STATE) && (prev_state != DECODE_STATE);
  assign hev      = (state_o == HALT_STATE) && (prev_state != HALT_STATE);
  assign trig_hit = trig_any || (pc_out == trig_pc);
  assign record   = {pc_out, ir_out, rq0};

  assign rd.rd_valid = (count != '0);
  assign rd.rd_data  = mem[rd_ptr];

  assign full = (count == FULL_COUNT);
  assign pop  = rd.rd_valid && rd.rd_ready;

  // arm wins over any same-cycle event, so it gates the push request entirely.
  assign push_req = !arm && dev &&
                    ((cap_state == S_CAPTURE) || ((cap_state == S_ARMED) && trig_hit));
  assign push_ok   = push_req && (!full || pop);
  assign push_drop = push_req && full && !pop;

  always_comb begin
    state_nx = cap_state;
    if (arm) begin
      state_nx = S_ARMED;
    end else begin
      case (cap_state)
        S_ARMED:   if (dev && trig_hit) state_nx = S_CAPTURE;
        S_CAPTURE: if (hev) state_nx = S_STOPPED;
        default:   state_nx = cap_state;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cap_state  <= S_IDLE;
      prev_state <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      cap_state  <= state_nx;
      prev_state <= state_o;
      if (arm) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (push_ok) begin
          mem[wr_ptr] <= record;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (push_drop) overflow <= 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        // Simultaneous push and pop leaves the occupancy unchanged, even when full.
        case ({push_ok, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
// Self-checking bench for trace_capture: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_trace_capture;

  localparam int DEPTH = 8;
  localparam logic [3:0] DEC  = 4'd2;
  localparam logic [3:0] HALT = 4'd7;
  localparam logic [3:0] EXEC = 4'd3;

  logic        clock = 1'b0;
  logic        reset;
  logic        arm;
  logic        trig_any;
  logic [4:0]  trig_pc;
  logic [15:0] ir_out;
  logic [4:0]  pc_out;
  logic [3:0]  state_o;
  logic [15:0] rq0;
  logic [1:0]  cap_state;
  logic [3:0]  count;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  trace_capture_if rd_bus ();

  trace_capture #(.DEPTH(DEPTH), .AW(3), .DECODE_STATE(DEC), .HALT_STATE(HALT)) dut (
    .clock     (clock),
    .reset     (reset),
    .arm       (arm),
    .trig_any  (trig_any),
    .trig_pc   (trig_pc),
    .ir_out    (ir_out),
    .pc_out    (pc_out),
    .state_o   (state_o),
    .rq0       (rq0),
    .rd        (rd_bus),
    .cap_state (cap_state),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  // Reference model: a queue of records and a named capture mode.
  localparam int M_IDLE = 0, M_ARMED = 1, M_CAPTURE = 2, M_STOPPED = 3;
  logic [36:0] m_q[$];
  int          m_state = M_IDLE;
  logic        m_ovf = 1'b0;
  logic [3:0]  m_prev = 4'd0;
  logic        m_dev, m_hev, m_pop, m_want;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_state = M_IDLE;
      m_ovf   = 1'b0;
      m_prev  = 4'd0;
    end else begin
      m_dev  = (state_o == DEC) && (m_prev != DEC);
      m_hev  = (state_o == HALT) && (m_prev != HALT);
      m_pop  = (m_q.size() != 0) && rd_bus.rd_ready;
      m_want = 1'b0;
      if (arm) begin
        m_q.delete();
        m_ovf   = 1'b0;
        m_state = M_ARMED;
      end else begin
        if (m_state == M_ARMED && m_dev && (trig_any || pc_out == trig_pc)) begin
          m_want  = 1'b1;
          m_state = M_CAPTURE;
        end else if (m_state == M_CAPTURE) begin
          if (m_dev) m_want = 1'b1;
          else if (m_hev) m_state = M_STOPPED;
        end
        if (m_pop) void'(m_q.pop_front());
        if (m_want) begin
          if (m_q.size() < DEPTH) m_q.push_back({pc_out, ir_out, rq0});
          else m_ovf = 1'b1;
        end
      end
      m_prev = state_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic do_arm(input logic any, input logic [4:0] tpc);
    trig_any = any;
    trig_pc  = tpc;
    arm      = 1'b1;
    cyc();
    arm      = 1'b0;
  endtask

  task automatic instr(input logic [4:0] pc, input logic [15:0] ir, input logic [15:0] rq,
                       input int dec_cycles);
    pc_out  = pc;
    ir_out  = ir;
    rq0     = rq;
    state_o = DEC;
    repeat (dec_cycles) cyc();
    state_o = EXEC;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++; if (rd_bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", rd_bus.rd_valid); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (cap_state !== 2'b00) begin failures++; $display("FAIL reset_state: got %0d want 0", cap_state); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
    checks++; if (rd_bus.rd_data !== 37'd0) begin failures++; $display("FAIL reset_data: got %0h want 0", rd_bus.rd_data); end
    @(negedge clock);
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_capture_basic();
    do_reset();
    do_arm(1'b1, 5'd0);
    instr(5'd0, 16'h1000, 16'h0005, 1);
    instr(5'd1, 16'h2001, 16'h0005, 1);
    instr(5'd2, 16'h3002, 16'h0005, 1);
    checks++; if (count !== 4'd3) begin failures++; $display("FAIL basic_count: got %0d want 3", count); end
    checks++; if (cap_state !== 2'b10) begin failures++; $display("FAIL basic_state: got %0d want 2", cap_state); end
    checks++; if (rd_bus.rd_data !== {5'd0, 16'h1000, 16'h0005}) begin failures++; $display("FAIL basic_head: got %0h want %0h", rd_bus.rd_data, {5'd0, 16'h1000, 16'h0005}); end
    cyc();
    checks++; if (rd_bus.rd_data !== {5'd0, 16'h1000, 16'h0005}) begin failures++; $display("FAIL basic_stable: got %0h", rd_bus.rd_data); end
  endtask

  task automatic test_decode_hold();
    logic [36:0] exp0, exp1;
    exp0 = {5'd1, 16'hA1A1, 16'h0011};
    exp1 = {5'd2, 16'hB2B2, 16'h0022};
    do_arm(1'b1, 5'd0);
    instr(5'd1, 16'hA1A1, 16'h0011, 4);
    instr(5'd2, 16'hB2B2, 16'h0022, 1);
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL hold_count: got %0d want 2", count); end
    rd_bus.rd_ready = 1'b1;
    checks++; if (rd_bus.rd_data !== exp0) begin failures++; $display("FAIL hold_first: got %0h want %0h", rd_bus.rd_data, exp0); end
    cyc();
    checks++; if (rd_bus.rd_data !== exp1) begin failures++; $display("FAIL hold_second: got %0h want %0h", rd_bus.rd_data, exp1); end
    checks++; if (rd_bus.rd_valid !== 1'b1) begin failures++; $display("FAIL hold_valid1: got %0b want 1", rd_bus.rd_valid); end
    cyc();
    checks++; if (rd_bus.rd_valid !== 1'b0) begin failures++; $display("FAIL hold_empty: got %0b want 0", rd_bus.rd_valid); end
    cyc();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL hold_ready_empty: got %0d want 0", count); end
    rd_bus.rd_ready = 1'b0;
  endtask

  task automatic test_pc_trigger();
    logic [2:0] st_after [4];
    st_after = '{2'b01, 2'b01, 2'b10, 2'b10};
    do_arm(1'b0, 5'd4);
    for (int i = 0; i < 4; i++) begin
      instr(5'(i + 2), 16'(16'h4000 + i), 16'h00C0, 1);
      checks++; if (cap_state !== st_after[i][1:0]) begin failures++; $display("FAIL trig_state_pc%0d: got %0d want %0d", i + 2, cap_state, st_after[i][1:0]); end
    end
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL trig_count: got %0d want 2", count); end
    checks++; if (rd_bus.rd_data[36:32] !== 5'd4) begin failures++; $display("FAIL trig_head_pc: got %0d want 4", rd_bus.rd_data[36:32]); end
    rd_bus.rd_ready = 1'b1;
    cyc();
    rd_bus.rd_ready = 1'b0;
    checks++; if (rd_bus.rd_data[36:32] !== 5'd5) begin failures++; $display("FAIL trig_next_pc: got %0d want 5", rd_bus.rd_data[36:32]); end
  endtask

  task automatic test_overflow();
    int exp_pc [8];
    exp_pc = '{1, 2, 3, 4, 5, 6, 7, 10};
    do_arm(1'b1, 5'd0);
    for (int i = 0; i < 10; i++) instr(5'(i), 16'($urandom), 16'($urandom), 1);
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL ovf_count: got %0d want 8", count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
    checks++; if (rd_bus.rd_data[36:32] !== 5'd0) begin failures++; $display("FAIL ovf_head: got %0d want 0", rd_bus.rd_data[36:32]); end
    checks++; if (cap_state !== 2'b10) begin failures++; $display("FAIL ovf_state: got %0d want 2", cap_state); end
    rd_bus.rd_ready = 1'b1;
    pc_out  = 5'd10;
    ir_out  = 16'hABCD;
    state_o = DEC;
    cyc();
    rd_bus.rd_ready = 1'b0;
    state_o = EXEC;
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL ovf_pushpop_count: got %0d want 8", count); end
    rd_bus.rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (rd_bus.rd_data[36:32] !== 5'(exp_pc[i])) begin failures++; $display("FAIL ovf_drain%0d: got %0d want %0d", i, rd_bus.rd_data[36:32], exp_pc[i]); end
      cyc();
    end
    checks++; if (rd_bus.rd_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained: got %0b want 0", rd_bus.rd_valid); end
    rd_bus.rd_ready = 1'b0;
  endtask

  task automatic test_halt_stop();
    do_arm(1'b1, 5'd0);
    instr(5'd3, 16'h0303, 16'h0001, 1);
    instr(5'd4, 16'h0404, 16'h0002, 1);
    state_o = HALT;
    cyc();
    state_o = EXEC;
    cyc();
    checks++; if (cap_state !== 2'b11) begin failures++; $display("FAIL halt_state: got %0d want 3", cap_state); end
    instr(5'd5, 16'h0505, 16'h0003, 1);
    instr(5'd6, 16'h0606, 16'h0004, 1);
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL halt_count: got %0d want 2", count); end
    rd_bus.rd_ready = 1'b1;
    cyc();
    rd_bus.rd_ready = 1'b0;
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL halt_drain: got %0d want 1", count); end
    checks++; if (rd_bus.rd_data[36:32] !== 5'd4) begin failures++; $display("FAIL halt_head: got %0d want 4", rd_bus.rd_data[36:32]); end
    do_arm(1'b1, 5'd0);
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL rearm_count: got %0d want 0", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rearm_ovf: got %0b want 0", overflow); end
    checks++; if (cap_state !== 2'b01) begin failures++; $display("FAIL rearm_state: got %0d want 1", cap_state); end
  endtask

  task automatic test_async_reset();
    do_arm(1'b1, 5'd0);
    for (int i = 0; i < 5; i++) instr(5'(i + 8), 16'hEE00 + 16'(i), 16'h7777, 1);
    checks++; if (count !== 4'd5) begin failures++; $display("FAIL areset_pre: got %0d want 5", count); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (rd_bus.rd_valid !== 1'b0) begin failures++; $display("FAIL areset_valid: got %0b want 0", rd_bus.rd_valid); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL areset_count: got %0d want 0", count); end
    checks++; if (cap_state !== 2'b00) begin failures++; $display("FAIL areset_state: got %0d want 0", cap_state); end
    checks++; if (rd_bus.rd_data !== 37'd0) begin failures++; $display("FAIL areset_data: got %0h want 0", rd_bus.rd_data); end
    @(negedge clock);
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_random();
    do_arm(1'b1, 5'd0);
    for (int n = 0; n < 600; n++) begin
      checks++; if (count !== 4'(m_q.size())) begin failures++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, count, m_q.size()); end
      checks++; if (cap_state !== 2'(m_state)) begin failures++; $display("FAIL rnd_state@%0d: got %0d want %0d", n, cap_state, m_state); end
      checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rnd_ovf@%0d: got %0b want %0b", n, overflow, m_ovf); end
      checks++; if (rd_bus.rd_valid !== (m_q.size() != 0)) begin failures++; $display("FAIL rnd_valid@%0d: got %0b want %0b", n, rd_bus.rd_valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        checks++; if (rd_bus.rd_data !== m_q[0]) begin failures++; $display("FAIL rnd_data@%0d: got %0h want %0h", n, rd_bus.rd_data, m_q[0]); end
      end
      arm      = ($urandom_range(0, 39) == 0);
      trig_any = 1'($urandom_range(0, 1));
      trig_pc  = 5'($urandom_range(0, 7));
      pc_out   = 5'($urandom_range(0, 7));
      ir_out   = 16'($urandom);
      rq0      = 16'($urandom);
      case ($urandom_range(0, 5))
        0, 1:    state_o = DEC;
        2:       state_o = (n > 300) ? HALT : EXEC;
        3:       state_o = 4'd0;
        default: state_o = EXEC;
      endcase
      rd_bus.rd_ready = ($urandom_range(0, 2) == 0);
      cyc();
    end
    arm = 1'b0;
    rd_bus.rd_ready = 1'b0;
    state_o = EXEC;
  endtask

  initial begin
    reset = 1'b0;
    arm = 1'b0;
    trig_any = 1'b0;
    trig_pc = 5'd0;
    ir_out = 16'd0;
    pc_out = 5'd0;
    state_o = 4'd0;
    rq0 = 16'd0;
    rd_bus.rd_ready = 1'b0;
    test_reset();
    test_capture_basic();
    test_decode_hold();
    test_pc_trigger();
    test_overflow();
    test_halt_stop();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Instruction-trace buffer that consumes the processor's observation outputs: ir_out, pc_out, state_o and rq0.
- Once armed and triggered, it records one entry per executed instruction into a FIFO.
- A downstream reader (host bench, UART formatter or display scanner) drains the FIFO over a valid/ready handshake.
- It sits beside the processor top and never drives the processor.

Parameters:
DEPTH, 8, FIFO entries; power of 2, minimum 2
AW, 3, log2(DEPTH)
DECODE_STATE, 4'd2, state_o code of the processor decode state (capture point)
HALT_STATE, 4'd7, state_o code of the processor halt state

Ports:
clock  input  1  system clock, all logic on its rising edge
reset  input  1  asynchronous, active-low system reset
arm  input  1  one-cycle pulse: flush FIFO, clear overflow, enter ARMED
trig_any  input  1  1 = trigger on first decode after arm; 0 = trigger on PC match
trig_pc  input  5  trigger PC value, used when trig_any=0
ir_out  input  16  processor instruction register
pc_out  input  5  processor program counter
state_o  input  4  processor FSM current state
rq0  input  16  processor RF[0] contents
rd_valid  output  1  FIFO non-empty
rd_data  output  37  head entry {pc[36:32], ir[31:16], rq0[15:0]}
rd_ready  input  1  reader accepts head this cycle
cap_state  output  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 STOPPED
count  output  AW+1  entries held, 0..DEPTH
overflow  output  1  sticky: a capture event was dropped

Behaviour:
- Reset (reset=0, async): cap_state=IDLE, FIFO empty, count=0, rd_valid=0, rd_data=0, overflow=0, memory cleared, prev-state register=0.
- Decode event (dev): state_o==DECODE_STATE and registered previous state_o!=DECODE_STATE. At most one dev per instruction, even if decode lasts several cycles.
- Halt event (hev): state_o==HALT_STATE and previous state_o!=HALT_STATE.
- Record = {pc_out, ir_out, rq0}, sampled in the dev cycle.
- FSM transitions:
  - IDLE: arm -> ARMED.
  - ARMED: dev with (trig_any | pc_out==trig_pc) -> CAPTURE; that same dev is pushed.
  - CAPTURE: every dev pushes; hev -> STOPPED (no push on hev).
  - STOPPED: holds until arm.
- arm in any state: flush (pointers and count to 0), overflow=0, go ARMED next cycle. arm has priority over a same-cycle dev/hev; that event is not captured.
- A hev while ARMED is ignored; stay ARMED.
- Push accepted when count<DEPTH, or when a pop happens in the same cycle (full with simultaneous pop: count stays DEPTH).
- Push refused when full with no pop: entry dropped, overflow<=1 (sticky until arm or reset), capture stays in CAPTURE.
- Pop when rd_valid & rd_ready. rd_ready while empty: no effect.
- Pop continues in every state, including IDLE and STOPPED.
- Push and pop in the same cycle while empty: no bypass; the entry becomes visible next cycle.
- FIFO is first-word-fall-through:
  - rd_data = mem[rd_ptr] combinationally; rd_valid = (count!=0).
  - A pushed entry appears on rd_data one cycle after its dev cycle.
  - rd_data is stable while rd_valid & !rd_ready.
- Pointers are AW bits and wrap from DEPTH-1 to 0.
- count updates: +1 push only, -1 pop only, unchanged when both or neither occur.
- Reset asserted mid-capture: immediate return to reset values; partial data is discarded.

Test Plan:
1. Reset, then arm with trig_any=1; drive 3 decodes at PC 0,1,2 (ir 16'h1000,16'h2001,16'h3002, rq0=16'h0005), rd_ready=0 -> count=3, cap_state=CAPTURE, head rd_data={5'd0,16'h1000,16'h0005}.
2. Decode held 4 cycles, then a second decode -> exactly 2 entries. Assert rd_ready -> entries emerge in order; rd_valid falls after 2 pops.
3. trig_any=0, trig_pc=5'd4; decodes at PC 2,3,4,5 -> cap_state stays ARMED through PC 3, enters CAPTURE at PC 4; FIFO holds PC 4 and 5 only.
4. DEPTH=8, rd_ready=0, 10 decodes -> count=8, overflow=1, entries are PCs 0..7. Pop with a simultaneous 11th decode -> count stays 8, new tail = PC 10.
5. hev after 2 decodes -> cap_state=STOPPED; further decodes are not stored; FIFO still drains. Arm -> count=0, overflow=0, ARMED.
6. Assert reset mid-capture with count=5 -> rd_valid=0, count=0, cap_state=IDLE, rd_data=0 immediately, with no clock edge required.
